command_queue: RTL and testbench

Parametrised command queue between the READ (fetch) and DECODE stages of the CPU. READ pushes one DATA_W-bit command word per cycle. DECODE pops either one word or a two-word pair per request. The queue provides full/empty/occupancy status, registered back-pressure to both stages, and a synchronous flush for control-flow changes.

---
 rtl/command_queue.sv | 124 ++++++++++++
 tb/tb_command_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/command_queue.sv
// command_queue
// ---------------------------------------------------------------------------
// Command FIFO between the READ (fetch) and DECODE stages.
//
// READ pushes one DATA_W-bit word per cycle. DECODE pops one word, or a
// two-word pair, per request. Every state update happens on the falling edge
// of clk. A push and a pop on the same edge are both judged against the
// occupancy before that edge, so a word is never written through to the
// output in the cycle it arrives.
//
// Ports
//   clk           clock; state updates on the falling edge
//   reset         asynchronous, active-low reset
//   flush         synchronous clear; overrides any push or pop on that edge
//   comm_write    push request from READ
//   command_in    word to push
//   comm_read     pop request from DECODE
//   read_pair     pop size: 1 = two words, 0 = one word
//   command_out   popped data; first word in the upper half
//   out_valid     one-cycle pulse when command_out was loaded by a pop
//   pause_READ    registered: the last push was rejected
//   pause_DECODE  registered: the last pop was rejected
//   count         occupancy, 0..DEPTH
//   full / empty / almost_full  decoded from registered count only
// ---------------------------------------------------------------------------
module command_queue #(
    parameter int DATA_W   = 14,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      comm_write,
    input  logic [DATA_W-1:0]         command_in,
    input  logic                      comm_read,
    input  logic                      read_pair,
    output logic [2*DATA_W-1:0]       command_out,
    output logic                      out_valid,
    output logic                      pause_READ,
    output logic                      pause_DECODE,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];

    // Word storage. Not reset: validity is tracked by count alone.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic [AW:0]   pop_n;       // words removed by an accepted pop: 1 or 2
    logic          wr_acc;
    logic          rd_acc;
    logic [AW-1:0] rd_ptr_p1;   // second word of a pair, wraps with the buffer
    logic [AW:0]   count_next;

    always_comb begin
        pop_n      = {{(AW-1){1'b0}}, read_pair, ~read_pair};
        wr_acc     = comm_write & (count_reg < DEPTH_C);
        rd_acc     = comm_read & (count_reg >= pop_n);
        rd_ptr_p1  = rd_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
        // Both acceptances use the pre-edge count, so the result stays in
        // 0..DEPTH without further clamping.
        count_next = count_reg + {{AW{1'b0}}, wr_acc}
                   - (rd_acc ? pop_n : {(AW+1){1'b0}});
    end

    // Memory write port kept free of reset so it maps onto block RAM.
    always_ff @(negedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr_reg] <= command_in;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            command_out  <= '0;
            out_valid    <= 1'b0;
            pause_READ   <= 1'b0;
            pause_DECODE <= 1'b0;
        end else if (flush) begin
            // command_out deliberately holds across a flush.
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            out_valid    <= 1'b0;
            pause_READ   <= 1'b0;
            pause_DECODE <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + pop_n[AW-1:0];
                if (read_pair) begin
                    command_out <= {mem[rd_ptr_reg], mem[rd_ptr_p1]};
                end else begin
                    command_out <= {mem[rd_ptr_reg], {DATA_W{1'b0}}};
                end
            end
            count_reg    <= count_next;
            out_valid    <= rd_acc;
            pause_READ   <= comm_write & ~wr_acc;
            pause_DECODE <= comm_read & ~rd_acc;
        end
    end

    assign count       = count_reg;
    assign full        = (count_reg == DEPTH_C);
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= AF_C);

endmodule

// File: tb/tb_command_queue.sv
// Testbench for command_queue (DATA_W=14, DEPTH=16, AF_LEVEL=14).
// The DUT acts on falling edges; inputs are driven and outputs sampled
// right after rising edges. A behavioural word queue predicts acceptance,
// and expected pop data is queued when a pop is driven and compared when
// the DUT reports it.
module tb_command_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        comm_write;
    logic [13:0] command_in;
    logic        comm_read;
    logic        read_pair;
    logic [27:0] command_out;
    logic        out_valid;
    logic        pause_READ;
    logic        pause_DECODE;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;

    int errors = 0;
    int checks = 0;

    logic [13:0] mq[$];      // words the queue should hold, head first
    logic [27:0] exp_q[$];   // pending expected command_out values
    logic [27:0] exp_last;   // most recent expected command_out

    command_queue #(.DATA_W(14), .DEPTH(16), .AF_LEVEL(14)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .comm_write(comm_write), .command_in(command_in),
        .comm_read(comm_read), .read_pair(read_pair),
        .command_out(command_out), .out_valid(out_valid),
        .pause_READ(pause_READ), .pause_DECODE(pause_DECODE),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: predict, drive, let the falling edge act, sample at
    // the following rising edge, then score any pop.
    task automatic step(input logic w, input logic [13:0] d, input logic r,
                        input logic pr, input logic fl);
        int pre;
        logic wacc;
        logic racc;
        logic [27:0] e;
        logic [27:0] got;
        pre  = mq.size();
        wacc = w && !fl && (pre < 16);
        racc = r && !fl && (pre >= (pr ? 2 : 1));
        e = '0;
        if (racc) begin
            e[27:14] = mq.pop_front();
            if (pr) e[13:0] = mq.pop_front();
            exp_q.push_back(e);
            exp_last = e;
        end
        if (fl) mq.delete();
        if (wacc) mq.push_back(d);
        comm_write = w; command_in = d; comm_read = r; read_pair = pr; flush = fl;
        @(negedge clk);
        @(posedge clk);
        comm_write = 0; command_in = '0; comm_read = 0; read_pair = 0; flush = 0;
        $display("txn w=%0b d=%h r=%0b pair=%0b fl=%0b -> count=%0d ov=%0b out=%h pR=%0b pD=%0b",
                 w, d, r, pr, fl, count, out_valid, command_out, pause_READ, pause_DECODE);
        checks++;
        if (out_valid !== racc) begin
            errors++;
            $display("FAIL sb_valid: got %b expected %b", out_valid, racc);
        end
        if (racc) begin
            got = exp_q.pop_front();
            checks++;
            if (command_out !== got) begin
                errors++;
                $display("FAIL sb_data: got %h expected %h", command_out, got);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 0; comm_write = 0; command_in = '0; comm_read = 0; read_pair = 0;
        repeat (2) @(posedge clk);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b/%b expected 0/0", full, almost_full); end
        checks++; if (out_valid !== 1'b0 || pause_READ !== 1'b0 || pause_DECODE !== 1'b0) begin
            errors++; $display("FAIL rst_flags: got %b%b%b expected 000", out_valid, pause_READ, pause_DECODE); end
        checks++; if (command_out !== 28'h0) begin errors++; $display("FAIL rst_out: got %h expected 0", command_out); end
        reset = 1'b1;
    endtask

    task automatic fill16(input logic [13:0] base);
        for (int i = 1; i <= 16; i++) step(1, base + 14'(i), 0, 0, 0);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            step(1, 14'(i), 0, 0, 0);
            checks++; if (pause_READ !== 1'b0) begin errors++; $display("FAIL fill_pause%0d: got %b expected 0", i, pause_READ); end
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count%0d: got %0d expected %0d", i, count, i); end
            checks++; if (almost_full !== (i >= 14)) begin errors++; $display("FAIL fill_af%0d: got %b expected %b", i, almost_full, i >= 14); end
            checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full%0d: got %b expected %b", i, full, i == 16); end
        end
        step(1, 14'h0011, 0, 0, 0);
        checks++; if (pause_READ !== 1'b1) begin errors++; $display("FAIL over_pause: got %b expected 1", pause_READ); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL over_count: got %0d expected 16", count); end
    endtask

    task automatic test_pair_pop();
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1, 1, 0);
            checks++; if (count !== 5'(16 - 2 * k)) begin errors++; $display("FAIL pair_count%0d: got %0d expected %0d", k, count, 16 - 2 * k); end
            if (k == 1) begin
                checks++; if (command_out !== {14'h0001, 14'h0002}) begin errors++; $display("FAIL pair_first: got %h expected %h", command_out, {14'h0001, 14'h0002}); end
            end
            if (k == 2) begin
                checks++; if (command_out !== {14'h0003, 14'h0004}) begin errors++; $display("FAIL pair_second: got %h expected %h", command_out, {14'h0003, 14'h0004}); end
            end
        end
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL pair_empty: got %b/%0d expected 1/0", empty, count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) step(1, 14'h0100 + 14'(i), 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 14'h0A00 + 14'(i), 0, 0, 0);
        step(0, 0, 1, 1, 0);
        checks++; if (command_out !== {14'h0A00, 14'h0A01}) begin errors++; $display("FAIL wrap_pair0: got %h expected %h", command_out, {14'h0A00, 14'h0A01}); end
        step(0, 0, 1, 0, 0);
        // Read pointer now sits on the last index; this pair straddles 15 -> 0.
        step(0, 0, 1, 1, 0);
        checks++; if (command_out !== {14'h0A03, 14'h0A04}) begin errors++; $display("FAIL wrap_straddle: got %h expected %h", command_out, {14'h0A03, 14'h0A04}); end
        step(0, 0, 1, 0, 0);
        checks++; if (command_out !== {14'h0A05, 14'h0000}) begin errors++; $display("FAIL wrap_last: got %h expected %h", command_out, {14'h0A05, 14'h0000}); end
    endtask

    task automatic test_simultaneous();
        fill16(14'h0200);
        step(1, 14'h03FF, 1, 1, 0);
        checks++; if (pause_READ !== 1'b1 || pause_DECODE !== 1'b0) begin errors++; $display("FAIL sim_full_pause: got %b%b expected 10", pause_READ, pause_DECODE); end
        checks++; if (count !== 5'd14) begin errors++; $display("FAIL sim_full_count: got %0d expected 14", count); end
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0);
        step(1, 14'h0123, 1, 0, 0);
        checks++; if (pause_DECODE !== 1'b1 || pause_READ !== 1'b0) begin errors++; $display("FAIL sim_empty_pause: got %b%b expected 01", pause_READ, pause_DECODE); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL sim_empty_count: got %0d expected 1", count); end
        step(0, 0, 1, 1, 0);
        checks++; if (pause_DECODE !== 1'b1 || count !== 5'd1) begin errors++; $display("FAIL sim_one_pair: got %b/%0d expected 1/1", pause_DECODE, count); end
        step(1, 14'h0124, 1, 1, 0);
        checks++; if (pause_DECODE !== 1'b1 || count !== 5'd2) begin errors++; $display("FAIL sim_one_pair_push: got %b/%0d expected 1/2", pause_DECODE, count); end
        step(0, 0, 1, 0, 0);
        checks++; if (command_out !== {14'h0123, 14'h0000}) begin errors++; $display("FAIL sim_single: got %h expected %h", command_out, {14'h0123, 14'h0000}); end
        step(0, 0, 1, 0, 0);
        checks++; if (pause_DECODE !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL sim_drain: got %b/%b expected 0/1", pause_DECODE, empty); end
    endtask

    task automatic test_flush();
        logic [27:0] hold;
        hold = exp_last;
        for (int i = 0; i < 5; i++) step(1, 14'h0050 + 14'(i), 0, 0, 0);
        step(1, 14'h0055, 1, 0, 1);
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_count: got %0d/%b expected 0/1", count, empty); end
        checks++; if (out_valid !== 1'b0 || pause_READ !== 1'b0 || pause_DECODE !== 1'b0) begin
            errors++; $display("FAIL flush_flags: got %b%b%b expected 000", out_valid, pause_READ, pause_DECODE); end
        checks++; if (command_out !== hold) begin errors++; $display("FAIL flush_hold: got %h expected %h", command_out, hold); end
        step(1, 14'h0777, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        checks++; if (command_out !== {14'h0777, 14'h0000}) begin errors++; $display("FAIL flush_after: got %h expected %h", command_out, {14'h0777, 14'h0000}); end
    endtask

    task automatic test_reset_mid();
        fill16(14'h0300);
        step(1, 14'h03AA, 1, 1, 0);
        checks++; if (pause_READ !== 1'b1) begin errors++; $display("FAIL mid_pre_pause: got %b expected 1", pause_READ); end
        #1 reset = 1'b0;
        #1;
        mq.delete();
        exp_q.delete();
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_count: got %0d/%b expected 0/1", count, empty); end
        checks++; if (out_valid !== 1'b0 || pause_READ !== 1'b0 || pause_DECODE !== 1'b0) begin
            errors++; $display("FAIL mid_flags: got %b%b%b expected 000", out_valid, pause_READ, pause_DECODE); end
        checks++; if (command_out !== 28'h0) begin errors++; $display("FAIL mid_out: got %h expected 0", command_out); end
        #1 reset = 1'b1;
        @(posedge clk);
        step(1, 14'h00BB, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        checks++; if (command_out !== {14'h00BB, 14'h0000} || count !== 5'd0) begin
            errors++; $display("FAIL mid_resume: got %h/%0d expected %h/0", command_out, count, {14'h00BB, 14'h0000}); end
    endtask

    initial begin
        exp_last = '0;
        test_reset();
        test_fill();
        test_pair_pop();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
